// File: rtl/dmi_debug_module_if.sv
// DMI, core-control and system-bus signal bundle for the debug module.
// The slave modport is the debug module; master is the DTM/core/bus side.
interface dmi_debug_module_if;
    logic        dmi_req;
    logic [6:0]  dmi_addr;
    logic [31:0] dmi_wdata;
    logic [1:0]  dmi_op;
    logic        dmi_ack;
    logic [31:0] dmi_rdata;
    logic [1:0]  dmi_resp;
    logic        hart_halted;
    logic        haltreq;
    logic        resumereq;
    logic        ndmreset;
    logic        sb_req;
    logic        sb_we;
    logic [31:0] sb_addr;
    logic [31:0] sb_wdata;
    logic [31:0] sb_rdata;
    logic        sb_ack;

    modport slave (
        input  dmi_req, dmi_addr, dmi_wdata, dmi_op, hart_halted, sb_rdata, sb_ack,
        output dmi_ack, dmi_rdata, dmi_resp, haltreq, resumereq, ndmreset,
        output sb_req, sb_we, sb_addr, sb_wdata
    );

    modport master (
        output dmi_req, dmi_addr, dmi_wdata, dmi_op, hart_halted, sb_rdata, sb_ack,
        input  dmi_ack, dmi_rdata, dmi_resp, haltreq, resumereq, ndmreset,
        input  sb_req, sb_we, sb_addr, sb_wdata
    );
endinterface

// File: rtl/dmi_debug_module.sv
// Minimal RISC-V style debug module: DMI register file, run control and a
// system-bus access engine with timeout.
module dmi_debug_module #(
    parameter int unsigned SB_TIMEOUT = 256
) (
    input logic               clk,
    input logic               rst,
    dmi_debug_module_if.slave dmi
);
    localparam logic [6:0] AddrData0      = 7'h04;
    localparam logic [6:0] AddrDmcontrol  = 7'h10;
    localparam logic [6:0] AddrDmstatus   = 7'h11;
    localparam logic [6:0] AddrSbcs       = 7'h38;
    localparam logic [6:0] AddrSbaddress0 = 7'h39;
    localparam logic [6:0] AddrSbdata0    = 7'h3C;

    localparam logic [1:0] OpNop   = 2'd0;
    localparam logic [1:0] OpRead  = 2'd1;
    localparam logic [1:0] OpRsvd  = 2'd3;
    localparam logic [1:0] RespOk  = 2'd0;
    localparam logic [1:0] RespErr = 2'd2;

    localparam int unsigned TmrW = $clog2(SB_TIMEOUT) + 1;
    localparam logic [TmrW-1:0] TmrLast = TmrW'(SB_TIMEOUT - 1);

    typedef enum logic [2:0] {StIdle, StDecode, StSbWait, StAck, StRelease} state_e;

    state_e          state_q, state_d;
    logic [6:0]      addr_q, addr_d;
    logic [31:0]     wdata_q, wdata_d;
    logic [1:0]      op_q, op_d;
    logic            ack_q, ack_d;
    logic [31:0]     rdata_q, rdata_d;
    logic [1:0]      resp_q, resp_d;
    logic [31:0]     data0_q, data0_d;
    logic            dmactive_q, dmactive_d;
    logic            haltreq_q, haltreq_d;
    logic            ndmreset_q, ndmreset_d;
    logic            resumereq_q, resumereq_d;
    logic            readonaddr_q, readonaddr_d;
    logic            autoinc_q, autoinc_d;
    logic            readondata_q, readondata_d;
    logic [2:0]      sberror_q, sberror_d;
    logic [31:0]     sbaddress0_q, sbaddress0_d;
    logic [31:0]     sbdata0_q, sbdata0_d;
    logic            sb_req_q, sb_req_d;
    logic            sb_we_q, sb_we_d;
    logic [31:0]     sb_addr_q, sb_addr_d;
    logic [31:0]     sb_wdata_q, sb_wdata_d;
    logic [TmrW-1:0] tmr_q, tmr_d;

    logic        is_rd, wr_en, sb_ok;
    logic [31:0] dmstatus, sbcs;

    assign is_rd = (op_q == OpRead);
    // Only dmcontrol is writable while the module is inactive.
    assign wr_en = !is_rd && (dmactive_q || addr_q == AddrDmcontrol);
    assign sb_ok = (sberror_q == 3'd0);
    assign dmstatus = {20'd0, ~dmi.hart_halted, ~dmi.hart_halted, dmi.hart_halted,
                       dmi.hart_halted, 1'b1, 3'd0, 4'd2};
    assign sbcs = {11'd0, readonaddr_q, 3'd2, autoinc_q, readondata_q, sberror_q, 12'd0};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= StIdle;
            addr_q       <= '0;
            wdata_q      <= '0;
            op_q         <= '0;
            ack_q        <= 1'b0;
            rdata_q      <= '0;
            resp_q       <= '0;
            data0_q      <= '0;
            dmactive_q   <= 1'b0;
            haltreq_q    <= 1'b0;
            ndmreset_q   <= 1'b0;
            resumereq_q  <= 1'b0;
            readonaddr_q <= 1'b0;
            autoinc_q    <= 1'b0;
            readondata_q <= 1'b0;
            sberror_q    <= '0;
            sbaddress0_q <= '0;
            sbdata0_q    <= '0;
            sb_req_q     <= 1'b0;
            sb_we_q      <= 1'b0;
            sb_addr_q    <= '0;
            sb_wdata_q   <= '0;
            tmr_q        <= '0;
        end else begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            op_q         <= op_d;
            ack_q        <= ack_d;
            rdata_q      <= rdata_d;
            resp_q       <= resp_d;
            data0_q      <= data0_d;
            dmactive_q   <= dmactive_d;
            haltreq_q    <= haltreq_d;
            ndmreset_q   <= ndmreset_d;
            resumereq_q  <= resumereq_d;
            readonaddr_q <= readonaddr_d;
            autoinc_q    <= autoinc_d;
            readondata_q <= readondata_d;
            sberror_q    <= sberror_d;
            sbaddress0_q <= sbaddress0_d;
            sbdata0_q    <= sbdata0_d;
            sb_req_q     <= sb_req_d;
            sb_we_q      <= sb_we_d;
            sb_addr_q    <= sb_addr_d;
            sb_wdata_q   <= sb_wdata_d;
            tmr_q        <= tmr_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        op_d         = op_q;
        ack_d        = 1'b0;
        rdata_d      = rdata_q;
        resp_d       = resp_q;
        data0_d      = data0_q;
        dmactive_d   = dmactive_q;
        haltreq_d    = haltreq_q;
        ndmreset_d   = ndmreset_q;
        resumereq_d  = 1'b0;
        readonaddr_d = readonaddr_q;
        autoinc_d    = autoinc_q;
        readondata_d = readondata_q;
        sberror_d    = sberror_q;
        sbaddress0_d = sbaddress0_q;
        sbdata0_d    = sbdata0_q;
        sb_req_d     = sb_req_q;
        sb_we_d      = sb_we_q;
        sb_addr_d    = sb_addr_q;
        sb_wdata_d   = sb_wdata_q;
        tmr_d        = tmr_q;

        unique case (state_q)
            StIdle: begin
                if (dmi.dmi_req) begin
                    addr_d  = dmi.dmi_addr;
                    wdata_d = dmi.dmi_wdata;
                    op_d    = dmi.dmi_op;
                    state_d = StDecode;
                end
            end
            StDecode: begin
                state_d = StAck;
                rdata_d = '0;
                resp_d  = RespOk;
                if (op_q == OpRsvd) begin
                    resp_d = RespErr;
                end else if (op_q != OpNop) begin
                    case (addr_q)
                        AddrData0: begin
                            if (is_rd) rdata_d = data0_q;
                            else if (wr_en) data0_d = wdata_q;
                        end
                        AddrDmcontrol: begin
                            if (is_rd) begin
                                rdata_d = {haltreq_q, 1'b0, 28'd0, ndmreset_q, dmactive_q};
                            end else begin
                                dmactive_d  = wdata_q[0];
                                haltreq_d   = wdata_q[31] & wdata_q[0];
                                ndmreset_d  = wdata_q[1] & wdata_q[0];
                                resumereq_d = wdata_q[30] & dmi.hart_halted;
                            end
                        end
                        AddrDmstatus: begin
                            if (is_rd) rdata_d = dmstatus;
                        end
                        AddrSbcs: begin
                            if (is_rd) begin
                                rdata_d = sbcs;
                            end else if (wr_en) begin
                                readonaddr_d = wdata_q[20];
                                autoinc_d    = wdata_q[16];
                                readondata_d = wdata_q[15];
                                sberror_d    = sberror_q & ~wdata_q[14:12];
                            end
                        end
                        AddrSbaddress0: begin
                            if (is_rd) begin
                                rdata_d = sbaddress0_q;
                            end else if (wr_en) begin
                                sbaddress0_d = wdata_q;
                                if (readonaddr_q && sb_ok) begin
                                    sb_req_d  = 1'b1;
                                    sb_we_d   = 1'b0;
                                    sb_addr_d = wdata_q;
                                    tmr_d     = '0;
                                    state_d   = StSbWait;
                                end
                            end
                        end
                        AddrSbdata0: begin
                            if (is_rd) begin
                                // Old value is returned; the refill read lands afterwards.
                                rdata_d = sbdata0_q;
                                if (readondata_q && sb_ok) begin
                                    sb_req_d  = 1'b1;
                                    sb_we_d   = 1'b0;
                                    sb_addr_d = sbaddress0_q;
                                    tmr_d     = '0;
                                    state_d   = StSbWait;
                                end
                            end else if (wr_en) begin
                                sbdata0_d = wdata_q;
                                if (sb_ok) begin
                                    sb_req_d   = 1'b1;
                                    sb_we_d    = 1'b1;
                                    sb_addr_d  = sbaddress0_q;
                                    sb_wdata_d = wdata_q;
                                    tmr_d      = '0;
                                    state_d    = StSbWait;
                                end
                            end
                        end
                        default: resp_d = RespErr;
                    endcase
                end
            end
            StSbWait: begin
                if (dmi.sb_ack) begin
                    sb_req_d = 1'b0;
                    if (!sb_we_q) sbdata0_d = dmi.sb_rdata;
                    if (autoinc_q) sbaddress0_d = sbaddress0_q + 32'd4;
                    state_d = StAck;
                end else if (tmr_q == TmrLast) begin
                    sb_req_d  = 1'b0;
                    sberror_d = 3'd1;
                    state_d   = StAck;
                end else begin
                    tmr_d = tmr_q + 1'b1;
                end
            end
            StAck: begin
                ack_d   = 1'b1;
                state_d = StRelease;
            end
            StRelease: begin
                if (!dmi.dmi_req) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    assign dmi.dmi_ack   = ack_q;
    assign dmi.dmi_rdata = rdata_q;
    assign dmi.dmi_resp  = resp_q;
    assign dmi.haltreq   = haltreq_q;
    assign dmi.resumereq = resumereq_q;
    assign dmi.ndmreset  = ndmreset_q;
    assign dmi.sb_req    = sb_req_q;
    assign dmi.sb_we     = sb_we_q;
    assign dmi.sb_addr   = sb_addr_q;
    assign dmi.sb_wdata  = sb_wdata_q;
endmodule

// File: tb/tb_dmi_debug_module.sv
// Directed bench for dmi_debug_module: DMI registers, run control, system-bus
// transfers, timeout, error responses and reset behaviour.
module tb_dmi_debug_module;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    dmi_debug_module_if bus ();

    dmi_debug_module #(.SB_TIMEOUT(256)) dut (
        .clk (clk),
        .rst (rst),
        .dmi (bus)
    );

    int errors = 0;
    int checks = 0;

    logic [31:0] rd_v;
    logic [1:0]  resp_v;
    int          lat_v;

    // Bus responder controls and captures
    logic        sb_respond = 1'b1;
    int          sb_delay = 1;
    logic [31:0] sb_rd_val = 32'h0;
    logic        cap_we = 1'b0;
    logic [31:0] cap_addr = 32'h0;
    logic [31:0] cap_wdata = 32'h0;

    // Event counters sampled on the falling edge
    int   ack_cnt = 0;
    int   rq_cnt = 0;
    int   sb_starts = 0;
    int   hi_cnt = 0;
    logic sb_req_prev = 1'b0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic dmi_access(input logic [1:0] op, input logic [6:0] addr,
                              input logic [31:0] wd, output logic [31:0] rd,
                              output logic [1:0] resp, output int lat);
        @(negedge clk);
        bus.dmi_op    = op;
        bus.dmi_addr  = addr;
        bus.dmi_wdata = wd;
        bus.dmi_req   = 1'b1;
        rd   = 32'hxxxx_xxxx;
        resp = 2'bxx;
        lat  = 0;
        while (lat < 1000) begin
            @(negedge clk);
            lat++;
            if (bus.dmi_ack) break;
        end
        if (bus.dmi_ack) begin
            rd   = bus.dmi_rdata;
            resp = bus.dmi_resp;
        end else begin
            check("dmi_ack_wait_expired", 32'd0, 32'd1);
        end
        bus.dmi_req = 1'b0;
        @(negedge clk);
    endtask

    task automatic wr(input logic [6:0] a, input logic [31:0] d);
        dmi_access(2'd2, a, d, rd_v, resp_v, lat_v);
    endtask

    task automatic rd_chk(input string tag, input logic [6:0] a, input logic [31:0] exp);
        dmi_access(2'd1, a, 32'h0, rd_v, resp_v, lat_v);
        check(tag, rd_v, exp);
    endtask

    initial begin : responder
        int wait_cnt;
        wait_cnt = 0;
        bus.sb_ack   = 1'b0;
        bus.sb_rdata = 32'h0;
        forever begin
            @(negedge clk);
            bus.sb_ack = 1'b0;
            if (bus.sb_req && sb_respond) begin
                wait_cnt++;
                if (wait_cnt >= sb_delay) begin
                    bus.sb_ack   = 1'b1;
                    bus.sb_rdata = sb_rd_val;
                    cap_we       = bus.sb_we;
                    cap_addr     = bus.sb_addr;
                    cap_wdata    = bus.sb_wdata;
                    wait_cnt     = 0;
                end
            end else begin
                wait_cnt = 0;
            end
        end
    end

    initial begin : monitor
        forever begin
            @(negedge clk);
            if (bus.dmi_ack) ack_cnt++;
            if (bus.resumereq) rq_cnt++;
            if (bus.sb_req) hi_cnt++;
            if (bus.sb_req && !sb_req_prev) sb_starts++;
            sb_req_prev = bus.sb_req;
        end
    end

    initial begin : watchdog
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        int a0, s0, h0, r0;
        bus.dmi_req     = 1'b0;
        bus.dmi_addr    = 7'h0;
        bus.dmi_wdata   = 32'h0;
        bus.dmi_op      = 2'd0;
        bus.hart_halted = 1'b0;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_dmi_ack", bus.dmi_ack, 1'b0);
        check("rst_haltreq", bus.haltreq, 1'b0);
        check("rst_ndmreset", bus.ndmreset, 1'b0);
        check("rst_sb_req", bus.sb_req, 1'b0);
        check("rst_sb_addr", bus.sb_addr, 32'h0);
        rst = 1'b0;

        rd_chk("dmstatus_after_rst", 7'h11, 32'h0000_0C82);
        rd_chk("dmcontrol_after_rst", 7'h10, 32'h0);

        // Inactive module ignores data0 writes
        wr(7'h04, 32'hAAAA_5555);
        rd_chk("data0_inactive_wr", 7'h04, 32'h0);

        wr(7'h10, 32'h8000_0003);
        check("haltreq_set", bus.haltreq, 1'b1);
        check("ndmreset_set", bus.ndmreset, 1'b1);
        rd_chk("dmcontrol_rd1", 7'h10, 32'h8000_0003);
        wr(7'h10, 32'h0000_0001);
        check("haltreq_clr", bus.haltreq, 1'b0);
        check("ndmreset_clr", bus.ndmreset, 1'b0);
        rd_chk("dmcontrol_rd2", 7'h10, 32'h0000_0001);

        dmi_access(2'd2, 7'h04, 32'h1234_5678, rd_v, resp_v, lat_v);
        check("data0_wr_rdata", rd_v, 32'h0);
        check("data0_wr_resp", resp_v, 2'd0);
        check("data0_wr_latency", lat_v, 3);
        dmi_access(2'd1, 7'h04, 32'h0, rd_v, resp_v, lat_v);
        check("data0_rd", rd_v, 32'h1234_5678);
        check("data0_rd_resp", resp_v, 2'd0);
        check("data0_rd_latency", lat_v, 3);

        // resumereq only pulses while halted
        r0 = rq_cnt;
        wr(7'h10, 32'h4000_0001);
        check("resumereq_running", rq_cnt - r0, 0);
        bus.hart_halted = 1'b1;
        r0 = rq_cnt;
        wr(7'h10, 32'h4000_0001);
        check("resumereq_halted", rq_cnt - r0, 1);
        rd_chk("dmstatus_halted", 7'h11, 32'h0000_0382);
        rd_chk("dmcontrol_no_resume_bit", 7'h10, 32'h0000_0001);
        bus.hart_halted = 1'b0;

        // Bus write with autoincrement
        wr(7'h38, 32'h0001_0000);
        rd_chk("sbcs_autoinc", 7'h38, 32'h0005_0000);
        s0 = sb_starts;
        wr(7'h39, 32'h0000_1000);
        check("sbaddr_wr_no_bus", sb_starts - s0, 0);
        sb_delay = 2;
        wr(7'h3C, 32'hCAFE_F00D);
        check("sbwr_count", sb_starts - s0, 1);
        check("sbwr_we", cap_we, 1'b1);
        check("sbwr_addr", cap_addr, 32'h0000_1000);
        check("sbwr_wdata", cap_wdata, 32'hCAFE_F00D);
        rd_chk("sbaddr_autoinc", 7'h39, 32'h0000_1004);

        // Read on address with a 5-cycle bus
        wr(7'h38, 32'h0010_0000);
        sb_delay  = 5;
        sb_rd_val = 32'hDEAD_BEEF;
        wr(7'h39, 32'h0000_2000);
        check("sbrd_we", cap_we, 1'b0);
        check("sbrd_addr", cap_addr, 32'h0000_2000);
        rd_chk("sbdata0_after_rd", 7'h3C, 32'hDEAD_BEEF);
        rd_chk("sbcs_no_err", 7'h38, 32'h0014_0000);

        // Read on data returns the old value, then refills
        wr(7'h38, 32'h0000_8000);
        sb_delay  = 1;
        sb_rd_val = 32'h55AA_55AA;
        s0 = sb_starts;
        rd_chk("sbdata0_rod_old", 7'h3C, 32'hDEAD_BEEF);
        check("sbrod_count", sb_starts - s0, 1);
        check("sbrod_addr", cap_addr, 32'h0000_2000);
        wr(7'h38, 32'h0000_0000);
        rd_chk("sbdata0_rod_new", 7'h3C, 32'h55AA_55AA);

        // Timeout with no sb_ack
        wr(7'h38, 32'h0010_0000);
        sb_respond = 1'b0;
        h0 = hi_cnt;
        dmi_access(2'd2, 7'h39, 32'h0000_3000, rd_v, resp_v, lat_v);
        check("timeout_req_cycles", hi_cnt - h0, 256);
        check("timeout_resp", resp_v, 2'd0);
        check("timeout_sb_req_low", bus.sb_req, 1'b0);
        rd_chk("sbcs_sberror", 7'h38, 32'h0014_1000);
        s0 = sb_starts;
        wr(7'h39, 32'h0000_4000);
        check("sberror_blocks_bus", sb_starts - s0, 0);
        check("sberror_blocked_resp", resp_v, 2'd0);
        rd_chk("sbaddr_written_while_err", 7'h39, 32'h0000_4000);
        wr(7'h38, 32'h0000_7000);
        rd_chk("sbcs_w1c", 7'h38, 32'h0004_0000);

        // Unmapped read with dmi_req held for 10+ cycles
        @(negedge clk);
        a0 = ack_cnt;
        bus.dmi_op   = 2'd1;
        bus.dmi_addr = 7'h7F;
        bus.dmi_req  = 1'b1;
        rd_v   = 32'hFFFF_FFFF;
        resp_v = 2'd0;
        repeat (12) begin
            @(negedge clk);
            if (bus.dmi_ack) begin
                rd_v   = bus.dmi_rdata;
                resp_v = bus.dmi_resp;
            end
        end
        bus.dmi_req = 1'b0;
        repeat (2) @(negedge clk);
        check("unmapped_single_ack", ack_cnt - a0, 1);
        check("unmapped_resp", resp_v, 2'd2);
        check("unmapped_rdata", rd_v, 32'h0);

        dmi_access(2'd3, 7'h04, 32'hFFFF_FFFF, rd_v, resp_v, lat_v);
        check("op3_resp", resp_v, 2'd2);
        check("op3_rdata", rd_v, 32'h0);
        rd_chk("op3_no_change", 7'h04, 32'h1234_5678);
        dmi_access(2'd0, 7'h04, 32'h0, rd_v, resp_v, lat_v);
        check("nop_resp", resp_v, 2'd0);
        check("nop_rdata", rd_v, 32'h0);

        // Reset in the middle of a bus transfer
        wr(7'h38, 32'h0010_0000);
        @(negedge clk);
        bus.dmi_op    = 2'd2;
        bus.dmi_addr  = 7'h39;
        bus.dmi_wdata = 32'h0000_5000;
        bus.dmi_req   = 1'b1;
        repeat (6) @(negedge clk);
        check("midrst_sb_req_busy", bus.sb_req, 1'b1);
        a0 = ack_cnt;
        rst = 1'b1;
        #1;
        check("midrst_sb_req_drop", bus.sb_req, 1'b0);
        bus.dmi_req = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (4) @(negedge clk);
        check("midrst_no_ack", ack_cnt - a0, 0);
        rd_chk("dmstatus_after_midrst", 7'h11, 32'h0000_0C82);
        rd_chk("data0_after_midrst", 7'h04, 32'h0);
        rd_chk("sbcs_after_midrst", 7'h38, 32'h0004_0000);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
